imem_loader: RTL
================

Name: imem_loader

Overview:
- Initiator side of the instruction-memory init interface: receives a framed program image as a byte stream and drives the init-mode/write port of the fetch stage's instruction memory.
- Holds init_mode high while loading so the PC does not advance, then releases it so fetch starts from the reset PC.
- Sits between a byte source (UART receiver or testbench) and the instruction fetch stage.

Parameters:
- MAX_WORDS, 4096, largest accepted word count; must be ≤ 2^12.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load
- rx_valid  input  1  rx_data valid this cycle
- rx_data  input  8  stream byte
- rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready
- init_mode  output  1  holds fetch/PC during load
- write_enable  output  1  one-cycle write strobe to instruction memory
- init_address  output  12  word index being written
- init_instruction  output  32  word being written
- words_written  output  13  count of words written in the current load
- done  output  1  sticky; load completed with good checksum
- error  output  1  sticky; bad checksum or oversize length

Behaviour:
- Reset, synchronous and dominant: state=IDLE; all outputs 0; internal length, byte counter and checksum cleared. Reset mid-load aborts with no further writes and deasserts init_mode next cycle.
- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - Payload: N×4 bytes, each word little-endian (first byte = bits 7:0).
  - One checksum byte: XOR of all preceding frame bytes, including the length bytes.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start → LEN_LO.
  - Same edge: init_mode=1; done=0; error=0; words_written=0; checksum=0.
  - init_address is set to 0xFFF so the first write lands at 0.
  - start in any other state is ignored.
- rx_ready=1 only in LEN_LO, LEN_HI, DATA and CHECK. All state updates occur only on an accepted byte. Idle cycles (rx_valid=0) change nothing.
- LEN_HI accept: N is formed.
  - N > MAX_WORDS → ERROR.
  - N == 0 → CHECK.
  - Otherwise → DATA.
- DATA: bytes are shifted into a word assembler.
  - On the 4th byte of a word, the next cycle has write_enable=1 for exactly one cycle, with init_instruction = the assembled word and init_address incremented by 1 (wraps 0xFFF→0 on the first write).
  - words_written increments in the same cycle as write_enable.
  - rx_ready stays 1, so back-to-back bytes need no stall.
  - After the 4th byte of word N → CHECK.
- CHECK accept:
  - Byte equals the running XOR → DONE; done=1; init_mode=0 the next cycle.
  - Otherwise → ERROR; error=1; init_mode stays 1 so the CPU is held.
- init_address and init_instruction hold their last values between writes. write_enable is 0 outside the cycle after a word completes.
- done and error are mutually exclusive and are cleared only by reset or an accepted start.
- The checksum accumulates every accepted byte from LEN_LO through the last payload byte.

Test Plan:
- Good two-word load: start; stream 02 00 05 00 08 20 00 00 00 00 2F with rx_valid always high.
  - Required: write_enable pulses twice — addr 0 / 0x20080005, then addr 1 / 0x00000000.
  - words_written=2; done=1; init_mode falls the cycle after 2F is accepted.
- Same stream with gaps (rx_valid low 3 cycles between bytes): identical writes, values and final state; no write_enable during gaps.
- Same stream with checksum 2E:
  - Both writes still occur.
  - error=1, done=0, init_mode stays 1; a following start clears error and reloads from addr 0.
- Empty image: start; 00 00 00 → no write_enable; done=1; init_mode=0.
- Oversize: start; 01 10 (N=4097):
  - error=1 immediately after the second byte; rx_ready=0; no writes.
  - Later bytes are not accepted.
- Reset after 5 payload bytes of the good stream:
  - Next cycle: all outputs 0, state IDLE, no further write_enable.
  - A subsequent full good stream completes with done=1 and writes starting at addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory init loader: takes a framed, checksummed byte stream and
// drives the init-mode / write port of the fetch stage's instruction memory.
module imem_loader #(
    parameter int MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        init_mode,
    output logic        write_enable,
    output logic [11:0] init_address,
    output logic [31:0] init_instruction,
    output logic [12:0] words_written,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] length;
    logic [1:0]  byte_cnt;
    logic [7:0]  checksum;
    logic [23:0] assembler;
    logic        accept;
    logic [16:0] new_length;

    always_comb begin
        rx_ready = 1'b0;
        case (state)
            LEN_LO, LEN_HI, DATA, CHECK: rx_ready = 1'b1;
            default:                     rx_ready = 1'b0;
        endcase
    end

    assign accept     = rx_valid && rx_ready;
    assign new_length = {1'b0, rx_data, len_lo};

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            len_lo           <= 8'd0;
            length           <= 16'd0;
            byte_cnt         <= 2'd0;
            checksum         <= 8'd0;
            assembler        <= 24'd0;
            init_mode        <= 1'b0;
            write_enable     <= 1'b0;
            init_address     <= 12'd0;
            init_instruction <= 32'd0;
            words_written    <= 13'd0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state         <= LEN_LO;
                        init_mode     <= 1'b1;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        words_written <= 13'd0;
                        checksum      <= 8'd0;
                        byte_cnt      <= 2'd0;
                        // Pre-decrement so the first write's increment lands on word 0.
                        init_address  <= 12'hFFF;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_lo   <= rx_data;
                        checksum <= checksum ^ rx_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        checksum <= checksum ^ rx_data;
                        length   <= new_length[15:0];
                        byte_cnt <= 2'd0;
                        if (new_length > MAX_LEN) begin
                            state <= ERROR;
                            error <= 1'b1;
                        end else if (new_length == 17'd0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        checksum  <= checksum ^ rx_data;
                        byte_cnt  <= byte_cnt + 2'd1;
                        assembler <= {rx_data, assembler[23:8]};
                        if (byte_cnt == 2'd3) begin
                            write_enable     <= 1'b1;
                            init_instruction <= {rx_data, assembler};
                            init_address     <= init_address + 12'd1;
                            words_written    <= words_written + 13'd1;
                            if (({3'b000, words_written} + 16'd1) == length)
                                state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (rx_data == checksum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            init_mode <= 1'b0;
                        end else begin
                            // init_mode stays high so the CPU never runs a corrupt image.
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
